// File: rtl/teami_frame_pkg.sv
// rtl/teami_frame_pkg.sv - shared types and constants for the serial (8,4) Hamming frame path
package teami_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EVAL  = 2'd2
    } frame_state_e;

    // Code-bit positions inside the captured word W[7:0].
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int D0 = 3;
    localparam int P4 = 4;
    localparam int D1 = 5;
    localparam int D2 = 6;
    localparam int D3 = 7;

    // Width of the serial bit counter (counts W0..W7).
    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/teami_hamming_check.sv
// rtl/teami_hamming_check.sv - combinational (8,4) syndrome, classification and single-bit correction
//
// Ports:
//   w_i     captured code word W[7:0]
//   dd_o    data nibble {W7,W6,W5,W3}; corrected when a single error was found, raw otherwise
//   ok_o    frame clean or single-error corrected
//   corr_o  a single-bit correction was applied
//   err_o   uncorrectable (double) error
module teami_hamming_check
    import teami_frame_pkg::*;
(
    input  logic [7:0] w_i,
    output logic [3:0] dd_o,
    output logic       ok_o,
    output logic       corr_o,
    output logic       err_o
);

    logic [2:0] syn;
    logic       par;
    logic [7:0] fixed;

    always_comb begin
        syn[0] = w_i[P1] ^ w_i[D0] ^ w_i[D1] ^ w_i[D3];
        syn[1] = w_i[P2] ^ w_i[D0] ^ w_i[D2] ^ w_i[D3];
        syn[2] = w_i[P4] ^ w_i[D1] ^ w_i[D2] ^ w_i[D3];
        par    = ^w_i;
        // Odd overall parity means one flipped bit at position syn (syn=0 -> W0).
        fixed  = w_i ^ (par ? (8'd1 << syn) : 8'd0);
        dd_o   = {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
        ok_o   = par | (syn == 3'd0);
        corr_o = par;
        err_o  = ~par & (syn != 3'd0);
    end

endmodule

// File: rtl/teami_frame_sequencer.sv
// rtl/teami_frame_sequencer.sv - serial Hamming frame capture, evaluation, output handshake and statistics
//
// Ports:
//   CLOCK      system clock, rising edge
//   NRESET     asynchronous active-low reset
//   DSTROBE    marks the cycle in which DDATA carries W0
//   DDATA      serial code bit, W0 first
//   DACK       consumer accepts the presented nibble
//   CLR_STATS  synchronous clear of counters and OVERRUN
//   DD         decoded nibble {W7,W6,W5,W3}
//   DREADY     DD/flags valid, held until DACK
//   DVALID     clean or corrected frame
//   DCORR      single-bit correction applied
//   DERROR     uncorrectable frame, DD carries raw bits
//   OVERRUN    sticky: result overwritten while DREADY was still high
//   CNT_OK     saturating count of clean frames
//   CNT_CORR   saturating count of corrected frames
//   CNT_ERR    saturating count of uncorrectable frames
module teami_frame_sequencer
    import teami_frame_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLOCK,
    input  logic             NRESET,
    input  logic             DSTROBE,
    input  logic             DDATA,
    input  logic             DACK,
    input  logic             CLR_STATS,
    output logic [3:0]       DD,
    output logic             DREADY,
    output logic             DVALID,
    output logic             DCORR,
    output logic             DERROR,
    output logic             OVERRUN,
    output logic [CNT_W-1:0] CNT_OK,
    output logic [CNT_W-1:0] CNT_CORR,
    output logic [CNT_W-1:0] CNT_ERR
);

    frame_state_e         state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [7:0]           word_q;
    logic [3:0]           dd_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 corr_q;
    logic                 err_q;
    logic                 overrun_q;
    logic [CNT_W-1:0]     cnt_ok_q;
    logic [CNT_W-1:0]     cnt_corr_q;
    logic [CNT_W-1:0]     cnt_err_q;

    logic [3:0]           chk_dd;
    logic                 chk_ok;
    logic                 chk_corr;
    logic                 chk_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // word_q is only complete while in EVAL, which is the only state that uses these results.
    teami_hamming_check u_check (
        .w_i    (word_q),
        .dd_o   (chk_dd),
        .ok_o   (chk_ok),
        .corr_o (chk_corr),
        .err_o  (chk_err)
    );

    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            dd_q       <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            corr_q     <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_ok_q   <= '0;
            cnt_corr_q <= '0;
            cnt_err_q  <= '0;
        end else begin
            // Acknowledge; a same-cycle EVAL load below takes precedence.
            if (ready_q && DACK) begin
                ready_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (DSTROBE) begin
                        word_q    <= {7'd0, DDATA};
                        bit_cnt_q <= BIT_CNT_W'(1);
                        state_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (DSTROBE) begin
                        // Restart: partial frame dropped, this bit is the new W0.
                        word_q    <= {7'd0, DDATA};
                        bit_cnt_q <= BIT_CNT_W'(1);
                    end else begin
                        word_q[bit_cnt_q] <= DDATA;
                        bit_cnt_q         <= bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            state_q <= EVAL;
                        end
                    end
                end

                EVAL: begin
                    dd_q    <= chk_dd;
                    valid_q <= chk_ok;
                    corr_q  <= chk_corr;
                    err_q   <= chk_err;
                    ready_q <= 1'b1;
                    if (ready_q && !DACK) begin
                        overrun_q <= 1'b1;
                    end
                    if (chk_corr) begin
                        cnt_corr_q <= sat_inc(cnt_corr_q);
                    end else if (chk_err) begin
                        cnt_err_q <= sat_inc(cnt_err_q);
                    end else begin
                        cnt_ok_q <= sat_inc(cnt_ok_q);
                    end
                    if (DSTROBE) begin
                        word_q    <= {7'd0, DDATA};
                        bit_cnt_q <= BIT_CNT_W'(1);
                        state_q   <= SHIFT;
                    end else begin
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Clear beats any increment or overrun set in the same cycle.
            if (CLR_STATS) begin
                cnt_ok_q   <= '0;
                cnt_corr_q <= '0;
                cnt_err_q  <= '0;
                overrun_q  <= 1'b0;
            end
        end
    end

    assign DD       = dd_q;
    assign DREADY   = ready_q;
    assign DVALID   = valid_q;
    assign DCORR    = corr_q;
    assign DERROR   = err_q;
    assign OVERRUN  = overrun_q;
    assign CNT_OK   = cnt_ok_q;
    assign CNT_CORR = cnt_corr_q;
    assign CNT_ERR  = cnt_err_q;

endmodule

// File: tb/tb_teami_frame_sequencer.sv
// tb/tb_teami_frame_sequencer.sv - self-checking bench for teami_frame_sequencer
module tb_teami_frame_sequencer;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLOCK = 1'b0;
    logic             NRESET;
    logic             DSTROBE;
    logic             DDATA;
    logic             DACK;
    logic             CLR_STATS;
    logic [3:0]       DD;
    logic             DREADY;
    logic             DVALID;
    logic             DCORR;
    logic             DERROR;
    logic             OVERRUN;
    logic [CNT_W-1:0] CNT_OK;
    logic [CNT_W-1:0] CNT_CORR;
    logic [CNT_W-1:0] CNT_ERR;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (frame-level view of the outputs).
    logic [3:0] m_dd;
    bit         m_ready, m_valid, m_corr, m_err, m_overrun;
    int         m_ok, m_cr, m_er;

    always #5 CLOCK = ~CLOCK;

    teami_frame_sequencer #(.CNT_W(CNT_W)) dut (
        .CLOCK     (CLOCK),
        .NRESET    (NRESET),
        .DSTROBE   (DSTROBE),
        .DDATA     (DDATA),
        .DACK      (DACK),
        .CLR_STATS (CLR_STATS),
        .DD        (DD),
        .DREADY    (DREADY),
        .DVALID    (DVALID),
        .DCORR     (DCORR),
        .DERROR    (DERROR),
        .OVERRUN   (OVERRUN),
        .CNT_OK    (CNT_OK),
        .CNT_CORR  (CNT_CORR),
        .CNT_ERR   (CNT_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".DD"},       32'(DD),       32'(m_dd));
        chk({tag, ".DREADY"},   32'(DREADY),   32'(m_ready));
        chk({tag, ".DVALID"},   32'(DVALID),   32'(m_valid));
        chk({tag, ".DCORR"},    32'(DCORR),    32'(m_corr));
        chk({tag, ".DERROR"},   32'(DERROR),   32'(m_err));
        chk({tag, ".OVERRUN"},  32'(OVERRUN),  32'(m_overrun));
        chk({tag, ".CNT_OK"},   32'(CNT_OK),   32'(m_ok));
        chk({tag, ".CNT_CORR"}, 32'(CNT_CORR), 32'(m_cr));
        chk({tag, ".CNT_ERR"},  32'(CNT_ERR),  32'(m_er));
    endtask

    task automatic model_reset();
        m_dd = '0; m_ready = 0; m_valid = 0; m_corr = 0; m_err = 0; m_overrun = 0;
        m_ok = 0; m_cr = 0; m_er = 0;
    endtask

    // Syndrome as the XOR of the indices of all set bits among W1..W7.
    function automatic void ref_decode(input logic [7:0] w, output logic [3:0] dd,
                                       output bit v, output bit c, output bit e);
        int         s = 0;
        logic [7:0] x = w;
        for (int i = 1; i < 8; i++) if (w[i]) s ^= i;
        if ($countones(w) % 2 == 1) begin
            x[s] = ~x[s]; v = 1; c = 1; e = 0;
        end else if (s == 0) begin
            v = 1; c = 0; e = 0;
        end else begin
            v = 0; c = 0; e = 1;
        end
        dd = {x[7], x[6], x[5], x[3]};
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] w = '0;
        int         s = 0;
        w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
        for (int i = 1; i < 8; i++) if (w[i]) s ^= i;
        w[1] = s[0]; w[2] = s[1]; w[4] = s[2];
        w[0] = ^w[7:1];
        return w;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // One clock cycle: inputs applied at the negedge, model advanced at the posedge.
    task automatic tick(input logic stb, input logic dat, input logic ack, input logic clr,
                        input bit is_eval, input logic [7:0] w);
        logic [3:0] dd;
        bit         v, c, e;
        DSTROBE = stb; DDATA = dat; DACK = ack; CLR_STATS = clr;
        @(posedge CLOCK);
        if (is_eval) begin
            ref_decode(w, dd, v, c, e);
            if (m_ready && !ack) m_overrun = 1;
            m_ready = 1; m_dd = dd; m_valid = v; m_corr = c; m_err = e;
            if (c) m_cr = sat(m_cr);
            else if (e) m_er = sat(m_er);
            else m_ok = sat(m_ok);
        end else if (ack) begin
            m_ready = 0;
        end
        if (clr) begin
            m_ok = 0; m_cr = 0; m_er = 0; m_overrun = 0;
        end
        @(negedge CLOCK);
        DSTROBE = 0; DACK = 0; CLR_STATS = 0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] w, input logic ack_eval,
                             input logic clr_eval, input bit skip0, input logic nstb,
                             input logic ndat, input bit rnd_ack);
        for (int i = (skip0 ? 1 : 0); i < 8; i++)
            tick(i == 0, w[i], rnd_ack ? 1'($urandom) : 1'b0, 1'b0, 1'b0, w);
        chk({tag, ".pre_eval_ready"}, 32'(DREADY), 32'(m_ready));
        tick(nstb, nstb ? ndat : 1'($urandom), ack_eval, clr_eval, 1'b1, w);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] part;
        logic [7:0] w;
        logic [7:0] w2;
        int         a, b, nflip, gap;

        NRESET = 0; DSTROBE = 0; DDATA = 0; DACK = 0; CLR_STATS = 0;
        model_reset();
        repeat (3) @(negedge CLOCK);
        check_all("reset");
        NRESET = 1;
        @(negedge CLOCK);

        // Clean frame W=AA.
        run_frame("clean_aa", 8'hAA, 0, 0, 0, 0, 0, 0);
        chk("clean_aa.dd_const", 32'(DD), 32'h0B);
        chk("clean_aa.cnt_const", 32'(CNT_OK), 32'd1);
        tick(0, 0, 1, 0, 0, 8'h00);
        check_all("ack_aa");

        // Single error in W5, single error in W0, double error.
        run_frame("single_8a", 8'h8A, 0, 0, 0, 0, 0, 0);
        chk("single_8a.dcorr_const", 32'(DCORR), 32'd1);
        tick(0, 0, 1, 0, 0, 8'h00);
        run_frame("single_ab", 8'hAB, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 8'h00);
        run_frame("double_ac", 8'hAC, 0, 0, 0, 0, 0, 0);
        chk("double_ac.derr_const", 32'(DERROR), 32'd1);
        tick(0, 0, 1, 0, 0, 8'h00);
        check_all("after_acks");

        // Abort after four bits, then a full clean frame.
        part = 8'h5C;
        for (int i = 0; i < 4; i++) tick(i == 0, part[i], 0, 0, 0, part);
        check_all("abort_partial");
        run_frame("abort_full", 8'hAA, 0, 0, 0, 0, 0, 0);

        // Overrun: previous result still pending when the next one loads.
        run_frame("overrun", 8'h8A, 0, 0, 0, 0, 0, 0);
        chk("overrun.flag_const", 32'(OVERRUN), 32'd1);
        // DACK in the EVAL cycle: load wins.
        run_frame("ack_in_eval", 8'hAA, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 8'h00);
        check_all("isolated_ack");
        tick(0, 0, 1, 0, 0, 8'h00);
        check_all("ack_while_idle");

        // Saturation, then clear in an EVAL cycle that would also set OVERRUN.
        tick(0, 0, 0, 1, 0, 8'h00);
        check_all("clr_idle");
        for (int k = 0; k < 4; k++) begin
            run_frame("sat", 8'hAA, 0, 0, 0, 0, 0, 0);
        end
        chk("sat.cnt_ok_const", 32'(CNT_OK), 32'(CMAX));
        run_frame("clr_in_eval", 8'hAA, 0, 1, 0, 0, 0, 0);
        chk("clr_in_eval.cnt_const", 32'(CNT_OK), 32'd0);
        chk("clr_in_eval.ovr_const", 32'(OVERRUN), 32'd0);

        // Back-to-back: next DSTROBE lands in the EVAL cycle.
        w2 = 8'hAC;
        run_frame("b2b_first", 8'hAA, 1, 0, 0, 1, w2[0], 0);
        run_frame("b2b_second", w2, 1, 0, 1, 0, 0, 0);

        // Randomized frames from valid codewords with 0..2 flipped bits.
        for (int f = 0; f < 40; f++) begin
            w = encode(4'($urandom));
            nflip = $urandom_range(0, 2);
            a = $urandom_range(0, 7);
            b = (a + 1 + $urandom_range(0, 6)) % 8;
            if (nflip >= 1) w[a] = ~w[a];
            if (nflip == 2) w[b] = ~w[b];
            run_frame("rand", w, 1'($urandom), ($urandom_range(0, 7) == 0), 0, 0, 0, 1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick(0, 1'($urandom), 1'($urandom), 0, 0, 8'h00);
        end
        check_all("rand_end");

        // Reset pulsed in the middle of a frame takes effect without a clock edge.
        w = 8'hAA;
        for (int i = 0; i < 3; i++) tick(i == 0, w[i], 0, 0, 0, w);
        #2 NRESET = 0;
        model_reset();
        #1 check_all("async_reset");
        @(negedge CLOCK);
        NRESET = 1;
        @(negedge CLOCK);
        run_frame("post_reset", 8'hAA, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
